lms_adapt_ctrl: RTL and testbench
=================================

// Module: lms_adapt_ctrl
// PURPOSE
//  Sequencer for the FSE LMS tap-update datapath. Drives its shift enable, tap-update enable and synchronous reset.
//  Inputs arrive at T/2. Taps update once per symbol, on every 2nd shift.
//  Startup: flush (hold taps at 1+j0), fill the NUM_TAPS delay line, then adapt with a gear-shifted step schedule.
//  Sits between the input sample stream/slicer timing and the LMS block.
// PARAMETERS
//  NUM_TAPS   11  delay-line length; number of samples shifted before adaptation starts
//  FLUSH_CYC   4  clk cycles o_lms_reset stays high in FLUSH (>=1)
//  NUM_GEARS   4  number of step-size gears; o_step_sel saturates at NUM_GEARS-1
//  GEAR_LEN  256  tap updates spent in each gear before shifting to the next (>=1)
//  NB_GEAR     2  width of o_step_sel, equals clog2(NUM_GEARS)
//  NB_CNT     16  width of the internal update/fill counters and o_upd_cnt
// PORTS
//  clk           in   1        system clock
//  i_reset       in   1        asynchronous reset, active-low
//  i_enable      in   1        level; 0 forces IDLE from any state
//  i_restart     in   1        1-cycle pulse; restarts the sequence at FLUSH
//  i_valid       in   1        one new T/2 sample present at LMS input this cycle
//  i_freeze      in   1        level; suspends tap updates (shifting continues)
//  i_tap_phase   in   1        T/2 phase (0/1) on which taps update
//  o_lms_reset   out  1        synchronous active-high reset to LMS block
//  o_en_shtr     out  1        LMS shift-register enable
//  o_en_taps     out  1        LMS tap-update enable
//  o_step_sel    out  NB_GEAR  current gear index, 0 = largest step
//  o_state       out  3        encoded FSM state, for debug
//  o_upd_cnt     out  NB_CNT   total tap updates since FLUSH, saturating
// BEHAVIOUR
//  State encoding: IDLE=0, FLUSH=1, FILL=2, ADAPT=3, FROZEN=4. State, counters and phase are registered.
//  Reset (i_reset=0): state IDLE, o_lms_reset=1, o_step_sel=0, o_upd_cnt=0, phase=0, strobes 0.
//  Strobes are a combinational decode of registered state & i_valid. Zero latency: aligned with the sample now at the LMS input.
//  Transition priority, highest first:
//   1. i_enable=0 -> IDLE.
//   2. i_restart=1 -> FLUSH.
//   3. Normal transitions:
//    - IDLE -> FLUSH when i_enable=1.
//    - FLUSH -> FILL after FLUSH_CYC cycles in FLUSH.
//    - FILL -> ADAPT on the NUM_TAPS-th i_valid. Phase=0 on ADAPT entry.
//    - ADAPT <-> FROZEN follows i_freeze, next cycle.
//  Entering FLUSH clears the fill count, o_upd_cnt, the gear counter and o_step_sel.
//  o_lms_reset = 1 in IDLE and FLUSH, else 0. The restart pulse cycle still counts as FLUSH cycle 1 once FLUSH is entered.
//  o_en_shtr = i_valid in FILL, ADAPT and FROZEN; 0 in IDLE and FLUSH.
//  Phase toggles on each i_valid in ADAPT and FROZEN, so phase tracking survives a freeze.
//  o_en_taps = i_valid & (phase==i_tap_phase) & (state==ADAPT) & ~i_freeze.
//   i_freeze gates the same cycle it rises.
//  On each o_en_taps:
//   - o_upd_cnt++ (saturates at all-ones).
//   - gear_cnt++. When gear_cnt reaches GEAR_LEN-1 and o_step_sel<NUM_GEARS-1: o_step_sel++, gear_cnt=0.
//   - In the last gear, gear_cnt holds.
//  i_valid=0: no strobes, counters and phase hold.
//  i_valid during IDLE/FLUSH is dropped. i_restart during FLUSH re-arms the FLUSH_CYC count.
//  i_tap_phase change mid-ADAPT takes effect on the next i_valid. No partial-symbol recovery.
// STRUCTURE
//  Shared package entries:
//   - state encoding constants (LMS_ST_IDLE..LMS_ST_FROZEN, 3 bits)
//   - default NUM_GEARS/GEAR_LEN
//   - step-per-gear table consumed by the step-selectable LMS variant
//  One sub-module: lms_gear_sched. Holds gear_cnt and o_step_sel, with inputs clear and upd_stb.
//  The FSM, fill counter and phase stay in the top module.
// TESTING
//  1. Hold i_reset=0, then release with i_enable=1.
//     -> IDLE, o_lms_reset=1.
//     -> FLUSH for exactly 4 cycles.
//     -> FILL, no o_en_shtr before the first i_valid.
//  2. i_valid every cycle in FILL.
//     -> o_en_shtr on 11 cycles, ADAPT on cycle 12.
//     -> with i_tap_phase=0, o_en_taps on ADAPT cycles 1,3,5,...
//  3. GEAR_LEN=4, NUM_GEARS=4, continuous updates.
//     -> o_step_sel 0->1->2->3 after updates 4, 8 and 12, holds 3 after update 16.
//     -> o_upd_cnt counts 1..N.
//  4. Assert i_freeze for 5 valid samples mid-ADAPT.
//     -> o_en_taps=0 from the same cycle, o_en_shtr continues.
//     -> after release, updates resume on the original phase parity.
//  5. i_restart pulse mid-ADAPT.
//     -> FLUSH next cycle, o_lms_reset=1 for 4 cycles.
//     -> o_step_sel=0, o_upd_cnt=0, refill of 11 samples.
//  6. Drop i_enable during FILL, and separately assert i_reset=0 mid-ADAPT.
//     -> IDLE immediately (async for reset), all strobes 0, o_lms_reset=1.

Source files
------------

// File: rtl/lms_adapt_ctrl_pkg.sv
// Shared definitions for the FSE LMS adaptation sequencer and its step-selectable LMS consumer.
// Latency: none, constants, types and a pure lookup function only.
// Backpressure: none.
package lms_adapt_ctrl_pkg;

   // Debug-visible sequencer state encoding
   typedef enum logic [2:0] {
      LMS_ST_IDLE   = 3'd0,
      LMS_ST_FLUSH  = 3'd1,
      LMS_ST_FILL   = 3'd2,
      LMS_ST_ADAPT  = 3'd3,
      LMS_ST_FROZEN = 3'd4
   } lms_state_t;

   localparam int LMS_NUM_GEARS_DEF = 4;
   localparam int LMS_GEAR_LEN_DEF  = 256;

   // Right-shift applied to the error*sample product in each gear; gear 0 is the largest step
   localparam logic [LMS_NUM_GEARS_DEF-1:0][3:0] LMS_STEP_SHIFT_TBL = {4'd10, 4'd9, 4'd8, 4'd7};

   function automatic logic [3:0] lms_step_shift(input logic [1:0] gear);
      return LMS_STEP_SHIFT_TBL[gear];
   endfunction

endpackage

// File: rtl/lms_adapt_ctrl_if.sv
// Control/status bundle between the sample-timing side and the LMS adaptation sequencer.
// Latency: none, wires only.
// Backpressure: none; i_valid is a per-cycle qualifier with no ready.
interface lms_adapt_ctrl_if #(
   parameter int NB_GEAR = 2,
   parameter int NB_CNT  = 16
);
   logic               i_enable;
   logic               i_restart;
   logic               i_valid;
   logic               i_freeze;
   logic               i_tap_phase;
   logic               o_lms_reset;
   logic               o_en_shtr;
   logic               o_en_taps;
   logic [NB_GEAR-1:0] o_step_sel;
   logic [2:0]         o_state;
   logic [NB_CNT-1:0]  o_upd_cnt;

   modport master (
      output i_enable, i_restart, i_valid, i_freeze, i_tap_phase,
      input  o_lms_reset, o_en_shtr, o_en_taps, o_step_sel, o_state, o_upd_cnt
   );

   modport slave (
      input  i_enable, i_restart, i_valid, i_freeze, i_tap_phase,
      output o_lms_reset, o_en_shtr, o_en_taps, o_step_sel, o_state, o_upd_cnt
   );
endinterface

// File: rtl/lms_gear_sched.sv
// Step-size gear scheduler: walks step_sel from 0 up to NUM_GEARS-1 every GEAR_LEN tap updates.
// Latency: step_sel changes the cycle after the update that completes a gear.
// Backpressure: none; counts only on upd_stb, clear wins over upd_stb.
module lms_gear_sched #(
   parameter int NUM_GEARS = 4,
   parameter int GEAR_LEN  = 256,
   parameter int NB_GEAR   = 2,
   parameter int NB_CNT    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               upd_stb,
   output logic [NB_GEAR-1:0] step_sel
);

   localparam logic [NB_GEAR-1:0] LAST_GEAR = NB_GEAR'(NUM_GEARS - 1);
   localparam logic [NB_CNT-1:0]  GEAR_END  = NB_CNT'(GEAR_LEN - 1);

   logic [NB_CNT-1:0] gear_cnt;

   // Count updates within the current gear; shift gear at the end, freeze everything in the last gear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gear_cnt <= '0;
         step_sel <= '0;
      end else if (clear) begin
         gear_cnt <= '0;
         step_sel <= '0;
      end else if (upd_stb && (step_sel < LAST_GEAR)) begin
         if (gear_cnt == GEAR_END) begin
            step_sel <= step_sel + NB_GEAR'(1);
            gear_cnt <= '0;
         end else begin
            gear_cnt <= gear_cnt + NB_CNT'(1);
         end
      end
   end

endmodule

// File: rtl/lms_adapt_ctrl.sv
// Sequencer for the FSE LMS tap update: flush, fill the delay line, then adapt once per symbol with gear-shifted steps.
// Latency: strobes are zero-latency decodes of registered state and the current i_valid; state moves next cycle.
// Backpressure: none; samples arriving in IDLE/FLUSH are dropped, i_freeze only gates tap updates.
module lms_adapt_ctrl
   import lms_adapt_ctrl_pkg::*;
#(
   parameter int NUM_TAPS  = 11,
   parameter int FLUSH_CYC = 4,
   parameter int NUM_GEARS = LMS_NUM_GEARS_DEF,
   parameter int GEAR_LEN  = LMS_GEAR_LEN_DEF,
   parameter int NB_GEAR   = 2,
   parameter int NB_CNT    = 16
) (
   input  logic            clk,
   input  logic            i_reset,
   lms_adapt_ctrl_if.slave bus
);

   localparam logic [NB_CNT-1:0] FLUSH_END = NB_CNT'(FLUSH_CYC - 1);
   localparam logic [NB_CNT-1:0] FILL_END  = NB_CNT'(NUM_TAPS - 1);

   lms_state_t         state;
   lms_state_t         nxt;
   logic [NB_CNT-1:0]  flush_cnt;
   logic [NB_CNT-1:0]  fill_cnt;
   logic [NB_CNT-1:0]  upd_cnt;
   logic               phase;
   logic               enter_flush;
   logic               lms_reset;
   logic               en_shtr;
   logic               en_taps;
   logic [NB_GEAR-1:0] step_sel;

   // State register
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= LMS_ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next state with enable/restart priority, plus strobe decode from registered state
   always_comb begin
      nxt         = state;
      enter_flush = 1'b0;
      lms_reset   = 1'b0;
      en_shtr     = 1'b0;
      en_taps     = 1'b0;

      if (!bus.i_enable) begin
         nxt = LMS_ST_IDLE;
      end else if (bus.i_restart) begin
         nxt         = LMS_ST_FLUSH;
         enter_flush = 1'b1;
      end else begin
         case (state)
            LMS_ST_IDLE: begin
               nxt         = LMS_ST_FLUSH;
               enter_flush = 1'b1;
            end
            LMS_ST_FLUSH: begin
               if (flush_cnt == FLUSH_END) nxt = LMS_ST_FILL;
            end
            LMS_ST_FILL: begin
               if (bus.i_valid && (fill_cnt == FILL_END)) nxt = LMS_ST_ADAPT;
            end
            LMS_ST_ADAPT: begin
               if (bus.i_freeze) nxt = LMS_ST_FROZEN;
            end
            LMS_ST_FROZEN: begin
               if (!bus.i_freeze) nxt = LMS_ST_ADAPT;
            end
            default: nxt = LMS_ST_IDLE;
         endcase
      end

      case (state)
         LMS_ST_IDLE, LMS_ST_FLUSH: lms_reset = 1'b1;
         LMS_ST_FILL, LMS_ST_FROZEN: en_shtr = bus.i_valid;
         LMS_ST_ADAPT: begin
            en_shtr = bus.i_valid;
            en_taps = bus.i_valid & (phase == bus.i_tap_phase) & ~bus.i_freeze;
         end
         default: lms_reset = 1'b1;
      endcase
   end

   // Cycles spent in FLUSH; any (re)entry, including a restart while flushing, starts over
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         flush_cnt <= '0;
      end else if (enter_flush) begin
         flush_cnt <= '0;
      end else if (state == LMS_ST_FLUSH) begin
         flush_cnt <= flush_cnt + NB_CNT'(1);
      end
   end

   // Samples shifted into the delay line during FILL
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         fill_cnt <= '0;
      end else if (enter_flush) begin
         fill_cnt <= '0;
      end else if ((state == LMS_ST_FILL) && bus.i_valid) begin
         fill_cnt <= fill_cnt + NB_CNT'(1);
      end
   end

   // T/2 phase: held at 0 until adaptation starts, then toggles per sample even while frozen
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         phase <= 1'b0;
      end else if ((state != LMS_ST_ADAPT) && (state != LMS_ST_FROZEN)) begin
         phase <= 1'b0;
      end else if (bus.i_valid) begin
         phase <= ~phase;
      end
   end

   // Saturating count of tap updates since the last flush
   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         upd_cnt <= '0;
      end else if (enter_flush) begin
         upd_cnt <= '0;
      end else if (en_taps && (upd_cnt != '1)) begin
         upd_cnt <= upd_cnt + NB_CNT'(1);
      end
   end

   lms_gear_sched #(
      .NUM_GEARS (NUM_GEARS),
      .GEAR_LEN  (GEAR_LEN),
      .NB_GEAR   (NB_GEAR),
      .NB_CNT    (NB_CNT)
   ) u_gear_sched (
      .clk      (clk),
      .rst_n    (i_reset),
      .clear    (enter_flush),
      .upd_stb  (en_taps),
      .step_sel (step_sel)
   );

   assign bus.o_lms_reset = lms_reset;
   assign bus.o_en_shtr   = en_shtr;
   assign bus.o_en_taps   = en_taps;
   assign bus.o_step_sel  = step_sel;
   assign bus.o_state     = state;
   assign bus.o_upd_cnt   = upd_cnt;

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Bench for lms_adapt_ctrl: startup table, gear walk, freeze, restart, enable drop and async reset.
// Latency: expected outputs are compared in the same cycle the stimulus is driven.
// Backpressure: none.
module tb_lms_adapt_ctrl;
   import lms_adapt_ctrl_pkg::*;

   typedef struct packed {
      logic rst;
      logic en;
      logic restart;
      logic valid;
      logic freeze;
      logic tap_phase;
   } stim_t;

   typedef struct packed {
      logic        lms_reset;
      logic        en_shtr;
      logic        en_taps;
      logic [1:0]  step_sel;
      logic [2:0]  state;
      logic [15:0] upd_cnt;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
      string nm;
   } vec_t;

   logic clk;
   logic i_reset;

   lms_adapt_ctrl_if #(.NB_GEAR(2), .NB_CNT(16)) bus ();

   lms_adapt_ctrl #(
      .NUM_TAPS  (11),
      .FLUSH_CYC (4),
      .NUM_GEARS (4),
      .GEAR_LEN  (4),
      .NB_GEAR   (2),
      .NB_CNT    (16)
   ) dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   exp_t  exp_q [$];
   string name_q [$];
   vec_t  tbl [64];
   int    ntbl;
   int    n_checks;
   int    n_fail;

   function automatic stim_t mk_s(input int rst, input int en, input int rs, input int v, input int fz, input int tp);
      stim_t s;
      s.rst       = (rst != 0);
      s.en        = (en != 0);
      s.restart   = (rs != 0);
      s.valid     = (v != 0);
      s.freeze    = (fz != 0);
      s.tap_phase = (tp != 0);
      return s;
   endfunction

   function automatic exp_t mk_e(input int lr, input int sh, input int tp, input int ss, input int st, input int uc);
      exp_t e;
      e.lms_reset = (lr != 0);
      e.en_shtr   = (sh != 0);
      e.en_taps   = (tp != 0);
      e.step_sel  = ss[1:0];
      e.state     = st[2:0];
      e.upd_cnt   = uc[15:0];
      return e;
   endfunction

   task automatic add(input stim_t s, input exp_t e, input string nm);
      tbl[ntbl].s  = s;
      tbl[ntbl].e  = e;
      tbl[ntbl].nm = nm;
      ntbl = ntbl + 1;
   endtask

   task automatic check_out();
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.lms_reset = bus.o_lms_reset;
      a.en_shtr   = bus.o_en_shtr;
      a.en_taps   = bus.o_en_taps;
      a.step_sel  = bus.o_step_sel;
      a.state     = bus.o_state;
      a.upd_cnt   = bus.o_upd_cnt;
      n_checks = n_checks + 1;
      if (a !== e) begin
         n_fail = n_fail + 1;
         $display("FAIL %s @%0t: got rst=%b shtr=%b taps=%b step=%0d st=%0d upd=%0d, want rst=%b shtr=%b taps=%b step=%0d st=%0d upd=%0d",
                  nm, $time, a.lms_reset, a.en_shtr, a.en_taps, a.step_sel, a.state, a.upd_cnt,
                  e.lms_reset, e.en_shtr, e.en_taps, e.step_sel, e.state, e.upd_cnt);
      end
   endtask

   // One clock cycle: drive just after posedge, compare on the falling edge
   task automatic run(input stim_t s, input exp_t e, input string nm);
      i_reset         = s.rst;
      bus.i_enable    = s.en;
      bus.i_restart   = s.restart;
      bus.i_valid     = s.valid;
      bus.i_freeze    = s.freeze;
      bus.i_tap_phase = s.tap_phase;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int u;
      int ss;
      clk      = 1'b0;
      n_checks = 0;
      n_fail   = 0;
      ntbl     = 0;
      i_reset  = 1'b1;
      bus.i_enable    = 1'b1;
      bus.i_restart   = 1'b0;
      bus.i_valid     = 1'b0;
      bus.i_freeze    = 1'b0;
      bus.i_tap_phase = 1'b0;
      #2 i_reset = 1'b0;

      // Startup: reset held (valid dropped), release, 4 flush cycles, fill, 40 adapt cycles with GEAR_LEN=4
      add(mk_s(0,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_IDLE,0), "rst_hold");
      add(mk_s(0,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_IDLE,0), "rst_hold");
      add(mk_s(1,1,0,0,0,0), mk_e(1,0,0,0,LMS_ST_IDLE,0), "rel_idle");
      for (int i = 0; i < 4; i++)
         add(mk_s(1,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "flush");
      add(mk_s(1,1,0,0,0,0), mk_e(0,0,0,0,LMS_ST_FILL,0), "fill_wait");
      for (int i = 0; i < 11; i++)
         add(mk_s(1,1,0,1,0,0), mk_e(0,1,0,0,LMS_ST_FILL,0), "fill");
      for (int k = 1; k <= 40; k++) begin
         u  = k / 2;
         ss = (u / 4 > 3) ? 3 : u / 4;
         add(mk_s(1,1,0,1,0,0), mk_e(0,1,(k % 2 == 1) ? 1 : 0,ss,LMS_ST_ADAPT,u), "adapt");
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < ntbl; i++)
         run(tbl[i].s, tbl[i].e, tbl[i].nm);

      // Freeze for 5 samples: gated the same cycle, shifting continues, parity preserved
      run(mk_s(1,1,0,1,1,0), mk_e(0,1,0,3,LMS_ST_ADAPT,20), "frz_same_cyc");
      for (int i = 0; i < 4; i++)
         run(mk_s(1,1,0,1,1,0), mk_e(0,1,0,3,LMS_ST_FROZEN,20), "frozen");
      run(mk_s(1,1,0,1,0,0), mk_e(0,1,0,3,LMS_ST_FROZEN,20), "unfrz_lag");
      run(mk_s(1,1,0,1,0,0), mk_e(0,1,1,3,LMS_ST_ADAPT,20), "resume");
      run(mk_s(1,1,0,1,0,0), mk_e(0,1,0,3,LMS_ST_ADAPT,21), "resume_odd");

      // Restart mid-ADAPT: 4 flush cycles with cleared counters, full 11-sample refill
      run(mk_s(1,1,1,0,0,0), mk_e(0,0,0,3,LMS_ST_ADAPT,21), "restart_cyc");
      for (int i = 0; i < 4; i++)
         run(mk_s(1,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "rs_flush");
      for (int i = 0; i < 11; i++)
         run(mk_s(1,1,0,1,0,0), mk_e(0,1,0,0,LMS_ST_FILL,0), "rs_fill");
      run(mk_s(1,1,0,1,0,0), mk_e(0,1,1,0,LMS_ST_ADAPT,0), "rs_adapt1");

      // Restart again, then restart inside FLUSH re-arms the flush length
      run(mk_s(1,1,1,0,0,0), mk_e(0,0,0,0,LMS_ST_ADAPT,1), "restart2");
      run(mk_s(1,1,0,0,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "rearm_f1");
      run(mk_s(1,1,1,0,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "rearm_f2");
      for (int i = 0; i < 4; i++)
         run(mk_s(1,1,0,0,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "rearm_flush");
      run(mk_s(1,1,0,0,0,0), mk_e(0,0,0,0,LMS_ST_FILL,0), "rearm_fill");

      // Drop enable during FILL: IDLE next cycle, strobes off; re-enable needs a full refill
      for (int i = 0; i < 3; i++)
         run(mk_s(1,1,0,1,0,0), mk_e(0,1,0,0,LMS_ST_FILL,0), "part_fill");
      run(mk_s(1,0,0,1,0,0), mk_e(0,1,0,0,LMS_ST_FILL,0), "en_drop_cyc");
      run(mk_s(1,0,0,1,0,0), mk_e(1,0,0,0,LMS_ST_IDLE,0), "en_off_idle");
      run(mk_s(1,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_IDLE,0), "reen_idle");
      for (int i = 0; i < 4; i++)
         run(mk_s(1,1,0,1,0,0), mk_e(1,0,0,0,LMS_ST_FLUSH,0), "reen_flush");
      for (int i = 0; i < 11; i++)
         run(mk_s(1,1,0,1,0,1), mk_e(0,1,0,0,LMS_ST_FILL,0), "reen_fill");

      // Tap phase 1: updates on even ADAPT cycles
      run(mk_s(1,1,0,1,0,1), mk_e(0,1,0,0,LMS_ST_ADAPT,0), "tp1_k1");
      run(mk_s(1,1,0,1,0,1), mk_e(0,1,1,0,LMS_ST_ADAPT,0), "tp1_k2");
      run(mk_s(1,1,0,1,0,1), mk_e(0,1,0,0,LMS_ST_ADAPT,1), "tp1_k3");
      run(mk_s(1,1,0,1,0,1), mk_e(0,1,1,0,LMS_ST_ADAPT,1), "tp1_k4");

      // Async reset mid-ADAPT: IDLE before the next clock edge
      run(mk_s(0,1,0,1,0,1), mk_e(1,0,0,0,LMS_ST_IDLE,0), "async_rst");
      run(mk_s(0,1,0,1,0,1), mk_e(1,0,0,0,LMS_ST_IDLE,0), "rst_hold2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
